// File: rtl/ow_pkg.sv
// ow_pkg: shared definitions for the 1-wire byte engine.
//   - command op codes seen on i_cmd_op
//   - bit positions inside the sockit_owm control register (address 0)
//   - engine state enum
//   - ow_ctrl_word(): control-register value written to start one slot
package ow_pkg;

    localparam logic [1:0] OW_OP_RST = 2'b00;  // reset / presence detect
    localparam logic [1:0] OW_OP_WR  = 2'b01;  // write one byte
    localparam logic [1:0] OW_OP_RD  = 2'b10;  // read one byte
    localparam logic [1:0] OW_OP_RSV = 2'b11;  // reserved, answered with err

    localparam int unsigned OWM_DAT = 0;  // data bit / sampled bit / presence (0 = present)
    localparam int unsigned OWM_RST = 1;  // request a reset pulse
    localparam int unsigned OWM_OVD = 2;  // overdrive, never used here
    localparam int unsigned OWM_CYC = 3;  // start / busy flag

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ARM,
        ST_WAIT,
        ST_NEXT,
        ST_RESP
    } ow_state_e;

    // Register value that starts one slot: reset pulse, write of 'wbit',
    // or a read slot (a read is a write-1 slot whose sampled DAT is kept).
    function automatic logic [3:0] ow_ctrl_word(input logic [1:0] op, input logic wbit);
        logic [3:0] w;
        w          = '0;
        w[OWM_CYC] = 1'b1;
        case (op)
            OW_OP_RST: w[OWM_RST] = 1'b1;
            OW_OP_WR:  w[OWM_DAT] = wbit;
            default:   w[OWM_DAT] = 1'b1;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ow_byte_engine.sv
// ow_byte_engine: turns byte-level 1-wire commands into sockit_owm register
// cycles (address 0 only), polls CYC for completion and returns one
// single-cycle response per command.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready   command handshake
//   i_cmd_op, i_cmd_data      00 reset/detect, 01 write, 10 read, 11 reserved
//   o_rsp_valid               one-cycle response strobe
//   o_rsp_data, o_rsp_err     response payload (zero outside the strobe)
//   o_bus_ren/wen/adr/wdt     sockit_owm bus master side
//   i_bus_rdt                 sockit_owm read data, valid while o_bus_ren = 1
module ow_byte_engine
    import ow_pkg::*;
#(
    parameter int unsigned BWD     = 32,
    parameter int unsigned TMO_CYC = 1_000_000
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_cmd_valid,
    output logic           o_cmd_ready,
    input  logic [1:0]     i_cmd_op,
    input  logic [7:0]     i_cmd_data,
    output logic           o_rsp_valid,
    output logic [7:0]     o_rsp_data,
    output logic           o_rsp_err,
    output logic           o_bus_ren,
    output logic           o_bus_wen,
    output logic           o_bus_adr,
    output logic [BWD-1:0] o_bus_wdt,
    input  logic [BWD-1:0] i_bus_rdt
);

    localparam int unsigned     TW      = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0]   TMO_MAX = TW'(TMO_CYC);

    ow_state_e      state_q, state_d;
    logic [1:0]     op_q;
    logic [7:0]     shift_q;
    logic [2:0]     bit_cnt_q;
    logic [TW-1:0]  tmo_q;
    logic           cyc_prev_q;
    logic           dat_q;
    logic           presence_q;
    logic           abort_q;     // timeout or reserved op: err with zero data
    logic [BWD-1:0] wdt_hold_q;

    logic           cyc;
    logic           dat;
    logic           tmo_hit;
    logic [BWD-1:0] wdt_issue;
    logic           unused_rdt;

    always_comb begin
        cyc        = i_bus_rdt[OWM_CYC];
        dat        = i_bus_rdt[OWM_DAT];
        unused_rdt = ^{i_bus_rdt[BWD-1:OWM_CYC+1], i_bus_rdt[OWM_OVD], i_bus_rdt[OWM_RST]};
        tmo_hit    = (tmo_q == TMO_MAX);
        wdt_issue  = BWD'(ow_ctrl_word(op_q, shift_q[0]));
    end

    // Next state and outputs.
    always_comb begin
        state_d     = state_q;
        o_cmd_ready = 1'b0;
        o_bus_wen   = 1'b0;
        o_bus_ren   = 1'b0;
        o_bus_adr   = 1'b0;
        o_bus_wdt   = wdt_hold_q;
        o_rsp_valid = 1'b0;
        o_rsp_data  = '0;
        o_rsp_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    state_d = (i_cmd_op == OW_OP_RSV) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_bus_wen = 1'b1;
                o_bus_wdt = wdt_issue;
                state_d   = ST_ARM;
            end
            ST_ARM: begin
                o_bus_ren = 1'b1;
                if (tmo_hit)  state_d = ST_RESP;
                else if (cyc) state_d = ST_WAIT;
                else          state_d = ST_NEXT;  // slot already finished
            end
            ST_WAIT: begin
                o_bus_ren = 1'b1;
                if (tmo_hit)                 state_d = ST_RESP;
                else if (cyc_prev_q && !cyc) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (op_q == OW_OP_RST || bit_cnt_q == 3'd7) state_d = ST_RESP;
                else                                        state_d = ST_ISSUE;
            end
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_err   = abort_q || (op_q == OW_OP_RST && !presence_q);
                if (!abort_q) begin
                    if (op_q == OW_OP_RST)     o_rsp_data = {7'd0, presence_q};
                    else if (op_q == OW_OP_RD) o_rsp_data = shift_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and datapath.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            tmo_q      <= '0;
            cyc_prev_q <= 1'b0;
            dat_q      <= 1'b0;
            presence_q <= 1'b0;
            abort_q    <= 1'b0;
            wdt_hold_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        op_q       <= i_cmd_op;
                        shift_q    <= i_cmd_data;
                        bit_cnt_q  <= '0;
                        presence_q <= 1'b0;
                        abort_q    <= (i_cmd_op == OW_OP_RSV);
                    end
                end
                ST_ISSUE: begin
                    tmo_q      <= '0;
                    cyc_prev_q <= 1'b0;
                    wdt_hold_q <= wdt_issue;
                end
                ST_ARM, ST_WAIT: begin
                    if (!tmo_hit) tmo_q <= tmo_q + TW'(1);
                    cyc_prev_q <= cyc;
                    if (state_d == ST_NEXT) dat_q   <= dat;
                    if (state_d == ST_RESP) abort_q <= 1'b1;
                end
                ST_NEXT: begin
                    case (op_q)
                        OW_OP_RST: presence_q <= ~dat_q;
                        OW_OP_WR:  shift_q    <= {1'b0, shift_q[7:1]};
                        default:   shift_q    <= {dat_q, shift_q[7:1]};
                    endcase
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
